// File: rtl/uart_resp_arb_if.sv
// Byte-request bus between three sources, the response arbiter and a UART transmitter.
// The slave modport is the arbiter side; the master modport is the source/transmitter side.
interface uart_resp_arb_if;
   logic       req0;
   logic       req1;
   logic       req2;
   logic [7:0] data0;
   logic [7:0] data1;
   logic [7:0] data2;
   logic       tx_done;
   logic       clr_ovf;
   logic       trmt;
   logic [7:0] resp;
   logic [2:0] pend;
   logic [2:0] ovf;
   logic       busy;

   modport slave (
      input  req0, req1, req2, data0, data1, data2, tx_done, clr_ovf,
      output trmt, resp, pend, ovf, busy
   );

   modport master (
      output req0, req1, req2, data0, data1, data2, tx_done, clr_ovf,
      input  trmt, resp, pend, ovf, busy
   );
endinterface

// File: rtl/uart_resp_arb.sv
// Three-source round-robin arbiter feeding one UART transmitter; each source owns a
// single-byte holding slot with a sticky overflow flag.

module uart_resp_slot (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req,
   input  logic [7:0] data,
   input  logic       gnt,
   input  logic       clr_ovf,
   output logic       pend,
   output logic [7:0] slot_byte,
   output logic       ovf
);
   logic       valid_q, valid_d;
   logic [7:0] data_q, data_d;
   logic       ovf_q, ovf_d;
   logic       drop;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      drop    = 1'b0;
      if (gnt) begin
         // A request landing on the grant edge refills the slot instead of overflowing.
         valid_d = req;
         if (req) data_d = data;
      end else if (req) begin
         if (!valid_q) begin
            valid_d = 1'b1;
            data_d  = data;
         end else begin
            drop = 1'b1;
         end
      end
      ovf_d = (ovf_q & ~clr_ovf) | drop;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= 8'h00;
         ovf_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         ovf_q   <= ovf_d;
      end
   end

   assign pend      = valid_q;
   assign slot_byte = data_q;
   assign ovf       = ovf_q;
endmodule

module uart_resp_arb (
   input  logic           clk,
   input  logic           rst_n,
   uart_resp_arb_if.slave bus
);
   localparam int NUM_SRC = 3;

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   state_t                    state_q, state_d;
   logic                      trmt_q, trmt_d;
   logic [7:0]                resp_q, resp_d;
   logic [1:0]                last_q, last_d;
   logic [NUM_SRC-1:0]        req_v, gnt_v, pend_v, ovf_v;
   logic [NUM_SRC-1:0][7:0]   data_v, slot_v;
   logic [1:0]                pick, cand;
   logic                      found;

   assign req_v  = {bus.req2, bus.req1, bus.req0};
   assign data_v = {bus.data2, bus.data1, bus.data0};

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_slot
      uart_resp_slot u_slot (
         .clk       (clk),
         .rst_n     (rst_n),
         .req       (req_v[i]),
         .data      (data_v[i]),
         .gnt       (gnt_v[i]),
         .clr_ovf   (bus.clr_ovf),
         .pend      (pend_v[i]),
         .slot_byte (slot_v[i]),
         .ovf       (ovf_v[i])
      );
   end

   // Search starts just past the last winner, so the last winner is checked last.
   always_comb begin
      found = 1'b0;
      pick  = last_q;
      cand  = 2'd0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         cand = 2'((int'(last_q) + k) % NUM_SRC);
         if (!found && pend_v[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      trmt_d  = 1'b0;
      resp_d  = resp_q;
      last_d  = last_q;
      gnt_v   = '0;
      case (state_q)
         IDLE: begin
            if (found) begin
               gnt_v[pick] = 1'b1;
               resp_d      = slot_v[pick];
               trmt_d      = 1'b1;
               last_d      = pick;
               state_d     = WAIT;
            end
         end
         WAIT: begin
            // tx_done may still read high from the previous byte while trmt is out.
            if (!trmt_q && bus.tx_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         trmt_q  <= 1'b0;
         resp_q  <= 8'h00;
         last_q  <= 2'd2;
      end else begin
         state_q <= state_d;
         trmt_q  <= trmt_d;
         resp_q  <= resp_d;
         last_q  <= last_d;
      end
   end

   assign bus.trmt = trmt_q;
   assign bus.resp = resp_q;
   assign bus.pend = pend_v;
   assign bus.ovf  = ovf_v;
   assign bus.busy = (state_q != IDLE);

   a_trmt_pulse: assert property (@(posedge clk) disable iff (!rst_n) trmt_q |=> !trmt_q);
   a_trmt_busy:  assert property (@(posedge clk) disable iff (!rst_n) trmt_q |-> state_q == WAIT);
endmodule

// File: doc/uart_resp_arb.md
UART_RESP_ARB -- requirements
Module: uart_resp_arb

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset, with ports named clk and rst_n.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req0 / req1 / req2  input  1 each  single-cycle request from source 0/1/2 to transmit one byte.
REQ-005 data0 / data1 / data2  input  8 each  byte to transmit, sampled in the same cycle as the matching req.
REQ-006 tx_done  input  1  UART transmitter done level: high when the transmitter is idle after a byte, low while shifting.
REQ-007 clr_ovf  input  1  single-cycle clear of all overflow flags.
REQ-008 trmt  output  1  registered one-cycle pulse that starts a UART transmission.
REQ-009 resp  output  8  registered byte presented to the UART transmitter; valid from the trmt cycle and held until the next grant.
REQ-010 pend  output  3  bit i high while source i's holding slot contains an untransmitted byte.
REQ-011 ovf  output  3  sticky bit i, set when a source-i request is dropped.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 Each source SHALL own a 1-entry holding slot: an 8-bit register plus a valid bit, with valid driving pend[i].
REQ-014 A req_i with slot i empty SHALL load data_i and set pend[i] at that edge.
REQ-015 Overflow, slot full and not granted that edge:
- a req_i SHALL be dropped;
- the slot contents SHALL be unchanged;
- ovf[i] SHALL be set.
REQ-016 A req_i on the same edge that slot i is granted SHALL be accepted: the slot reloads with the new byte, pend[i] stays 1, and ovf[i] is unchanged.
REQ-017 The FSM SHALL have exactly two states: IDLE and WAIT.
REQ-018 IDLE with any pend bit set, at the next edge:
- grant one source by round-robin;
- register resp <= that slot's byte;
- set trmt for exactly one cycle;
- clear that slot's pend bit (unless REQ-016 applies);
- update the last-grant pointer;
- go to WAIT.
REQ-019 IDLE with pend == 0 SHALL stay in IDLE with trmt low.
REQ-020 Round-robin search order SHALL be (last+1) mod 3, (last+2) mod 3, then last; the pointer holds the index of the most recent grant.
REQ-021 WAIT SHALL ignore tx_done in the cycle trmt is high.
REQ-022 WAIT SHALL return to IDLE at the first later edge where tx_done is 1.
REQ-023 No grant SHALL occur in the same edge as the WAIT->IDLE transition, so back-to-back grants are at least one IDLE cycle apart.
REQ-024 Latency: with the FSM idle and no contention, a req sampled at edge N SHALL produce trmt high in the cycle following edge N+1.
REQ-025 Requests SHALL continue to be accepted into empty slots while in WAIT.
REQ-026 clr_ovf SHALL clear all ovf bits; an overflow on the same edge SHALL leave its ovf bit set (set wins).
REQ-027 resp SHALL change only on a grant edge.
REQ-028 No byte SHALL ever be transmitted twice or reordered within a single source.

Reset
REQ-029 Reset assertion SHALL asynchronously force:
- trmt=0, resp=8'h00, pend=3'b000, ovf=3'b000;
- FSM=IDLE;
- last-grant pointer=2, so source 0 has first priority.
REQ-030 Reset mid-transmission SHALL discard all pending bytes, and no trmt SHALL occur until a new req after reset release.

Verification
REQ-031 Single request: idle, req1 with data1=8'hA5 at edge N -> trmt=1 and resp=8'hA5 after edge N+1, pend=000 after edge N+1, busy until tx_done seen.
REQ-032 Simultaneous requests: req0/req1/req2 with 8'h11/8'h22/8'h33 in the same cycle after reset -> transmit order 11, 22, 33, each grant only after tx_done returns high.
REQ-033 Round-robin fairness: source 0 requests again immediately after every grant while source 2 is pending -> grants alternate between 0 and 2, and source 2 is never starved.
REQ-034 Overflow: during WAIT, req2=8'h44 then req2=8'h55 -> ovf[2]=1, later transmit of 8'h44 only; clr_ovf together with a third dropped req2 -> ovf[2] stays 1.
REQ-035 Reload on grant: req0=8'h66 on the same edge slot 0 is granted with 8'h77 -> resp=8'h77 now, 8'h66 sent next, ovf[0]=0.
REQ-036 Reset during WAIT with two slots pending -> all outputs return to reset values asynchronously, and no trmt occurs without a new req.
